// File: rtl/prim_clk_div_pkg.sv
// prim_clk_div_pkg
// Shared types for the programmable clock divider.
//   clk_div_mode_e : output shape of a channel (single-cycle tick or ~50% square).
//   clk_div_cfg_t  : ratio/mode pair at the default counter width.
package prim_clk_div_pkg;

  // Default counter/ratio width; matches the divider's default CntW.
  localparam int unsigned CfgCntW = 8;

  typedef enum logic {
    DivPulse  = 1'b0,
    DivSquare = 1'b1
  } clk_div_mode_e;

  typedef struct packed {
    logic [CfgCntW-1:0] ratio;
    clk_div_mode_e      mode;
  } clk_div_cfg_t;

  localparam clk_div_cfg_t ClkDivCfgDefault = '{
    ratio: CfgCntW'(4),
    mode:  DivPulse
  };

endpackage

// File: rtl/prim_clk_div_ch.sv
// prim_clk_div_ch
// One divider channel: free-running counter, active and shadow config, pending flag and a
// registered output.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   en_i     : channel enable; low holds the counter at zero and the output low
//   load_i   : accepted config write for this channel (already qualified by ready)
//   ratio_i  : new ratio; zero is clamped to one when loaded into the shadow
//   mode_i   : new output mode
//   pend_o   : shadow loaded and not yet applied
//   out_o    : registered divided output
module prim_clk_div_ch
  import prim_clk_div_pkg::*;
#(
  parameter int unsigned CntW     = 8,
  parameter int unsigned RstRatio = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [CntW-1:0] ratio_i,
  input  clk_div_mode_e   mode_i,
  output logic            pend_o,
  output logic            out_o
);

  localparam logic [CntW-1:0] RstRatioW = CntW'(RstRatio);
  localparam logic [CntW-1:0] One       = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] ratio_q, ratio_d;
  logic [CntW-1:0] ratio_sh_q, ratio_sh_d;
  clk_div_mode_e   mode_q, mode_d;
  clk_div_mode_e   mode_sh_q, mode_sh_d;
  logic            pend_q, pend_d;
  logic            out_q, out_d;

  logic            wrap;
  logic            hi_phase;
  logic            apply;

  // Active ratio is never zero, so ratio_q - 1 cannot underflow.
  assign wrap     = (cnt_q == (ratio_q - One));
  // Upper half of the period is high; odd ratios get the extra cycle in the high phase.
  assign hi_phase = (cnt_q >= (ratio_q >> 1));

  always_comb begin
    cnt_d      = '0;
    ratio_d    = ratio_q;
    mode_d     = mode_q;
    ratio_sh_d = ratio_sh_q;
    mode_sh_d  = mode_sh_q;
    pend_d     = pend_q;
    out_d      = 1'b0;
    apply      = 1'b0;

    if (en_i) begin
      cnt_d = wrap ? '0 : (cnt_q + One);
      out_d = (mode_q == DivPulse) ? wrap : hi_phase;
      apply = wrap & pend_q;
    end else begin
      // An idle channel has no period to protect, so the shadow lands right away.
      apply = pend_q;
    end

    if (apply) begin
      ratio_d = ratio_sh_q;
      mode_d  = mode_sh_q;
      pend_d  = 1'b0;
    end

    // Loads are only accepted while not pending, so they never collide with apply.
    if (load_i) begin
      ratio_sh_d = (ratio_i == '0) ? One : ratio_i;
      mode_sh_d  = mode_i;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      ratio_q    <= RstRatioW;
      mode_q     <= DivPulse;
      ratio_sh_q <= RstRatioW;
      mode_sh_q  <= DivPulse;
      pend_q     <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      mode_q     <= mode_d;
      ratio_sh_q <= ratio_sh_d;
      mode_sh_q  <= mode_sh_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
    end
  end

  assign pend_o = pend_q;
  assign out_o  = out_q;

endmodule

// File: rtl/prim_clk_div_prog.sv
// prim_clk_div_prog
// Multi-channel runtime-programmable clock-enable / divided-clock generator. Each channel
// divides clk_i by its own ratio in pulse or square mode; new settings go through a
// valid/ready port into a per-channel shadow that takes effect at the channel's next wrap.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   testmode_i  : test bypass (only honoured with PRIM_CLK_DIV_PROG_TESTMODE_EN defined)
//   en_i        : per-channel enable
//   cfg_valid_i : config write request
//   cfg_ready_o : write accepted when high together with cfg_valid_i
//   cfg_ch_i    : target channel; out-of-range channels read ready and drop the write
//   cfg_ratio_i : new ratio (0 is treated as 1)
//   cfg_mode_i  : new mode, 0 = pulse, 1 = square
//   cfg_pend_o  : per-channel shadow-pending flags
//   clk_o       : per-channel divided output
// Build option: define PRIM_CLK_DIV_PROG_TESTMODE_EN to let testmode_i route clk_i to every
// clk_o. Without it clk_o is purely registered.
module prim_clk_div_prog
  import prim_clk_div_pkg::*;
#(
  parameter int unsigned NumCh    = 4,
  parameter int unsigned CntW     = 8,
  parameter int unsigned RstRatio = 4,
  localparam int unsigned ChW     = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             testmode_i,
  input  logic [NumCh-1:0] en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [ChW-1:0]   cfg_ch_i,
  input  logic [CntW-1:0]  cfg_ratio_i,
  input  logic             cfg_mode_i,
  output logic [NumCh-1:0] cfg_pend_o,
  output logic [NumCh-1:0] clk_o
);

  logic [NumCh-1:0] pend;
  logic [NumCh-1:0] load;
  logic [NumCh-1:0] out;

  // Channel decode and ready mux; a channel index with no match keeps ready high and
  // loads nothing.
  always_comb begin
    cfg_ready_o = 1'b1;
    load        = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      if (32'(cfg_ch_i) == i) begin
        cfg_ready_o = ~pend[i];
        load[i]     = cfg_valid_i & ~pend[i];
      end
    end
  end

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    prim_clk_div_ch #(
      .CntW     (CntW),
      .RstRatio (RstRatio)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (en_i[i]),
      .load_i  (load[i]),
      .ratio_i (cfg_ratio_i),
      .mode_i  (clk_div_mode_e'(cfg_mode_i)),
      .pend_o  (pend[i]),
      .out_o   (out[i])
    );
  end

  assign cfg_pend_o = pend;

`ifdef PRIM_CLK_DIV_PROG_TESTMODE_EN
  // Bypass only swaps the output; counters and config keep running underneath.
  assign clk_o = testmode_i ? {NumCh{clk_i}} : out;
`else
  logic unused_testmode;
  assign unused_testmode = testmode_i;
  assign clk_o           = out;
`endif

endmodule

// File: tb/tb_prim_clk_div_prog.sv
// tb_prim_clk_div_prog
// Self-checking bench for prim_clk_div_prog: directed vector table, hand-written corner
// sequences and randomized traffic against a period/position reference model.
module tb_prim_clk_div_prog;

  localparam int unsigned NumCh    = 4;
  localparam int unsigned CntW     = 8;
  localparam int unsigned RstRatio = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             testmode_i;
  logic [NumCh-1:0] en_i;
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [1:0]       cfg_ch_i;
  logic [CntW-1:0]  cfg_ratio_i;
  logic             cfg_mode_i;
  logic [NumCh-1:0] cfg_pend_o;
  logic [NumCh-1:0] clk_o;

  always #5 clk = ~clk;

  prim_clk_div_prog #(
    .NumCh    (NumCh),
    .CntW     (CntW),
    .RstRatio (RstRatio)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .testmode_i  (testmode_i),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_ratio_i (cfg_ratio_i),
    .cfg_mode_i  (cfg_mode_i),
    .cfg_pend_o  (cfg_pend_o),
    .clk_o       (clk_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: each channel tracks how many cycles it has been in its current run
  // (age); position in the period is age mod R.
  int m_age      [NumCh];
  int m_ratio    [NumCh];
  bit m_mode     [NumCh];
  bit m_pend     [NumCh];
  int m_sh_ratio [NumCh];
  bit m_sh_mode  [NumCh];
  bit m_out      [NumCh];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NumCh; i++) begin
      m_age[i]      = 0;
      m_ratio[i]    = RstRatio;
      m_mode[i]     = 1'b0;
      m_pend[i]     = 1'b0;
      m_sh_ratio[i] = RstRatio;
      m_sh_mode[i]  = 1'b0;
      m_out[i]      = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit acc;
    acc = cfg_valid_i && !m_pend[cfg_ch_i];
    for (int i = 0; i < NumCh; i++) begin
      if (en_i[i]) begin
        int pos;
        bit last;
        pos  = m_age[i] % m_ratio[i];
        last = (pos == m_ratio[i] - 1);
        // Square: the final ceil(R/2) positions of each period are high.
        if (m_mode[i]) m_out[i] = (pos >= m_ratio[i] - (m_ratio[i] + 1) / 2);
        else           m_out[i] = last;
        if (last && m_pend[i]) begin
          m_ratio[i] = m_sh_ratio[i];
          m_mode[i]  = m_sh_mode[i];
          m_pend[i]  = 1'b0;
          m_age[i]   = 0;
        end else begin
          m_age[i]++;
        end
      end else begin
        m_out[i] = 1'b0;
        m_age[i] = 0;
        if (m_pend[i]) begin
          m_ratio[i] = m_sh_ratio[i];
          m_mode[i]  = m_sh_mode[i];
          m_pend[i]  = 1'b0;
        end
      end
      if (acc && int'(cfg_ch_i) == i) begin
        m_sh_ratio[i] = (cfg_ratio_i == 0) ? 1 : int'(cfg_ratio_i);
        m_sh_mode[i]  = cfg_mode_i;
        m_pend[i]     = 1'b1;
      end
    end
  endtask

  function automatic logic [NumCh-1:0] model_out();
    logic [NumCh-1:0] v;
    for (int i = 0; i < NumCh; i++) v[i] = m_out[i];
    return v;
  endfunction

  function automatic logic [NumCh-1:0] model_pend();
    logic [NumCh-1:0] v;
    for (int i = 0; i < NumCh; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [NumCh-1:0] exp_clk();
    logic [NumCh-1:0] v;
    v = model_out();
`ifdef PRIM_CLK_DIV_PROG_TESTMODE_EN
    if (testmode_i) v = {NumCh{clk}};
`endif
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_clk_o", 32'(clk_o), 32'(exp_clk()));
    chk("model_cfg_pend_o", 32'(cfg_pend_o), 32'(model_pend()));
    chk("model_cfg_ready_o", 32'(cfg_ready_o), 32'(!m_pend[cfg_ch_i]));
  endtask

  task automatic do_reset();
    en_i        = '0;
    cfg_valid_i = 1'b0;
    cfg_ch_i    = '0;
    cfg_ratio_i = '0;
    cfg_mode_i  = 1'b0;
    testmode_i  = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("reset_clk_o", 32'(clk_o), 32'(0));
    chk("reset_cfg_pend_o", 32'(cfg_pend_o), 32'(0));
    chk("reset_cfg_ready_o", 32'(cfg_ready_o), 32'(1));
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [NumCh-1:0] en;
    logic             valid;
    logic [1:0]       ch;
    logic [CntW-1:0]  ratio;
    logic             mode;
    logic [NumCh-1:0] exp_clk;
    logic [NumCh-1:0] exp_pend;
    logic             exp_ready;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;

    // ch0 runs default R=4 pulse from row 0; ch1 gets R=5 square while idle (applies the
    // next clock) and is enabled from row 2.
    vecs[0]  = '{4'b0001, 1'b1, 2'd1, 8'd5, 1'b1, 4'b0000, 4'b0010, 1'b0};
    vecs[1]  = '{4'b0001, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[3]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0001, 4'b0000, 1'b1};
    vecs[4]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0010, 4'b0000, 1'b1};
    vecs[5]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0010, 4'b0000, 1'b1};
    vecs[6]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0010, 4'b0000, 1'b1};
    vecs[7]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0001, 4'b0000, 1'b1};
    vecs[8]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[9]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0010, 4'b0000, 1'b1};
    vecs[10] = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0010, 4'b0000, 1'b1};
    vecs[11] = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0011, 4'b0000, 1'b1};
    vecs[12] = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1};

    // Directed table.
    do_reset();
    for (int v = 0; v < 13; v++) begin
      en_i        = vecs[v].en;
      cfg_valid_i = vecs[v].valid;
      cfg_ch_i    = vecs[v].ch;
      cfg_ratio_i = vecs[v].ratio;
      cfg_mode_i  = vecs[v].mode;
      tick();
      chk($sformatf("vec%0d_clk_o", v), 32'(clk_o), 32'(vecs[v].exp_clk));
      chk($sformatf("vec%0d_pend", v), 32'(cfg_pend_o), 32'(vecs[v].exp_pend));
      chk($sformatf("vec%0d_ready", v), 32'(cfg_ready_o), 32'(vecs[v].exp_ready));
    end

    // Write R=2 to ch0 in its wrap cycle; old spacing holds one more period.
    do_reset();
    en_i = 4'b0001;
    repeat (3) tick();
    cfg_valid_i = 1'b1;
    cfg_ch_i    = 2'd0;
    cfg_ratio_i = 8'd2;
    cfg_mode_i  = 1'b0;
    tick();
    chk("wrap_write_old_pulse", 32'(clk_o[0]), 32'(1));
    chk("wrap_write_pend", 32'(cfg_pend_o[0]), 32'(1));
    cfg_ratio_i = 8'd7;
    chk("pending_ready_low", 32'(cfg_ready_o), 32'(0));
    for (int c = 5; c <= 14; c++) begin
      tick();
      cfg_valid_i = 1'b0;
      chk($sformatf("wrap_write_clk0_c%0d", c), 32'(clk_o[0]),
          32'((c == 8) || (c >= 10 && c % 2 == 0)));
      chk($sformatf("wrap_write_pend_c%0d", c), 32'(cfg_pend_o[0]), 32'(c < 8));
    end

    // R=0 clamps to 1; dropping enable forces the output low next cycle.
    do_reset();
    cfg_valid_i = 1'b1;
    cfg_ch_i    = 2'd2;
    cfg_ratio_i = 8'd0;
    cfg_mode_i  = 1'b0;
    tick();
    chk("r0_pend", 32'(cfg_pend_o[2]), 32'(1));
    cfg_valid_i = 1'b0;
    tick();
    chk("r0_applied_idle", 32'(cfg_pend_o[2]), 32'(0));
    en_i[2] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("r0_high_c%0d", c), 32'(clk_o[2]), 32'(1));
    end
    en_i[2] = 1'b0;
    tick();
    chk("disable_clk_low", 32'(clk_o[2]), 32'(0));

    // Randomized traffic against the model.
    do_reset();
    en_i = '1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        int k;
        k = int'($urandom_range(0, NumCh - 1));
        en_i[k] = ~en_i[k];
      end
      cfg_valid_i = ($urandom_range(0, 3) == 0);
      cfg_ch_i    = 2'($urandom_range(0, NumCh - 1));
      cfg_ratio_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40))
                                                : 8'($urandom_range(0, 9));
      cfg_mode_i  = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset mid-period with a write pending.
    do_reset();
    cfg_valid_i = 1'b1;
    cfg_ch_i    = 2'd0;
    cfg_ratio_i = 8'd8;
    cfg_mode_i  = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    tick();
    en_i = 4'b0001;
    tick();
    cfg_valid_i = 1'b1;
    cfg_ratio_i = 8'd3;
    cfg_mode_i  = 1'b0;
    tick();
    cfg_valid_i = 1'b0;
    repeat (4) tick();
    chk("pre_reset_square_high", 32'(clk_o[0]), 32'(1));
    chk("pre_reset_pend", 32'(cfg_pend_o[0]), 32'(1));
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("async_reset_clk_o", 32'(clk_o), 32'(0));
    chk("async_reset_pend", 32'(cfg_pend_o), 32'(0));
    chk("async_reset_ready", 32'(cfg_ready_o), 32'(1));
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("post_reset_clk0_c%0d", c), 32'(clk_o[0]), 32'(c == 4 || c == 8));
    end

    // Test bypass.
    do_reset();
    en_i       = 4'b0101;
    testmode_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
`ifdef PRIM_CLK_DIV_PROG_TESTMODE_EN
      chk("testmode_follow_high", 32'(clk_o), 32'({NumCh{1'b1}}));
`else
      chk("testmode_no_effect_high", 32'(clk_o), 32'(model_out()));
`endif
      @(negedge clk);
      #1;
      chk("testmode_low_phase", 32'(clk_o), 32'(exp_clk()));
    end
    testmode_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prim_clk_div_prog.md
# prim_clk_div_prog

Multi-channel, runtime-programmable clock-enable/divided-clock generator. It is the parametrised successor to the fixed-ratio single-channel divider. Each of `NumCh` channels divides `clk_i` by its own ratio and runs in either single-cycle pulse mode (a clock-enable tick) or square mode (approximately 50 % duty). Ratio and mode are written through a valid/ready config port into a per-channel shadow register, which takes effect glitch-free at the channel's next wrap. The block feeds peripheral baud/tick logic and slow-clock consumers in the SoC.

## Interface
Parameters:
- `NumCh`, 4: number of independent channels (≥1).
- `CntW`, 8: counter/ratio width; maximum ratio is 2^CntW−1.
- `RstRatio`, 4: active ratio of every channel after reset (1..2^CntW−1).

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `testmode_i`  in  1  test bypass; ignored unless the macro is defined.
- `en_i`  in  NumCh  per-channel enable.
- `cfg_valid_i`  in  1  config write request.
- `cfg_ready_o`  out  1  config write accepted when high together with valid.
- `cfg_ch_i`  in  $clog2(NumCh) (min 1)  target channel.
- `cfg_ratio_i`  in  CntW  new ratio R.
- `cfg_mode_i`  in  1  new mode: 0 = pulse, 1 = square.
- `cfg_pend_o`  out  NumCh  shadow loaded but not yet applied, per channel.
- `clk_o`  out  NumCh  per-channel registered output.

## Operation
- Per-channel state: `cnt_q[CntW]`, active `ratio_q` and `mode_q`, shadow `ratio_sh` and `mode_sh`, `pend_q`, output `out_q`.
- Reset: `cnt_q`=0, `ratio_q`=`RstRatio`, `mode_q`=pulse, `pend_q`=0, `out_q`=0. Outputs after reset: `clk_o`=0, `cfg_pend_o`=0, `cfg_ready_o`=1.
- Ratio value 0 is clamped to 1 at shadow load. No other illegal values exist.
- `cfg_ready_o` = ~`pend_q[cfg_ch_i]`. A `cfg_ch_i` ≥ NumCh gives `cfg_ready_o`=1, and the write is dropped.
- Accepted write (valid & ready) loads the shadow registers and sets `pend_q` of the target channel.
- Enabled channel:
  - If `cnt_q` == `ratio_q`−1 (wrap): `cnt_q` goes to 0.
  - At wrap, if `pend_q` is set, `ratio_q`/`mode_q` take the shadow values and `pend_q` clears.
  - Otherwise `cnt_q` increments.
- Disabled channel: `cnt_q` is held at 0 and `out_q` is 0. A pending shadow is applied on the next clock.
- Output, registered from the pre-update `cnt_q` and active config:
  - Pulse: `out_q` = en & (`cnt_q` == `ratio_q`−1).
  - Square: `out_q` = en & (`cnt_q` ≥ `ratio_q`>>1).
- R=1: pulse gives a constant-high tick; square gives constant high.
- Odd R in square mode: high phase is one cycle longer than the low phase.

## Timing
- Enable rises in cycle 0 with `cnt_q`=0. Pulse with R: `clk_o` is high in cycle R only, then every R cycles after that.
- Square with R=4: `clk_o` is low in cycles 1–2 and high in cycles 3–4, with period 4.
- Write accepted in the same cycle as the target channel's wrap: that wrap uses the old config. The new config applies at the following wrap, and `pend_q` stays 1 until then.
- Write to one channel while another wraps: the channels are independent.
- `pend_q` clears one cycle after the wrap that applies it. `cfg_ready_o` for that channel rises in that same cycle.
- `en_i` falling mid-period: next cycle `cnt_q`=0 and `clk_o`=0. No partial pulse is emitted later.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Shadow contents are discarded.

## Configuration
- Macro: `PRIM_CLK_DIV_PROG_TESTMODE_EN`.
- Defined: when `testmode_i`=1, every `clk_o` = `clk_i` combinationally. Counters and config logic keep running underneath.
- Undefined: `testmode_i` is unused and `clk_o` = `out_q` always. There is no combinational path from `clk_i` to outputs.

## Structure
- Package `prim_clk_div_pkg` holds:
  - `clk_div_mode_e` (`DivPulse`=1'b0, `DivSquare`=1'b1).
  - A `clk_div_cfg_t` struct (ratio, mode), parametrised via a `CntW`-width localparam default of 8.
- Sub-module `prim_clk_div_ch` implements one channel (counter, active/shadow config, pending flag, output register). The top instantiates it `NumCh` times and does config decode, the ready mux and the testmode mux.

## Test plan
- Reset, then enable ch0 with default R=4 pulse: `clk_o[0]` pulses in cycles 4, 8, 12; `cfg_ready_o`=1.
- Write ch1 R=5 square, then enable: period 5, low 2 cycles / high 3 cycles; `cfg_pend_o[1]` clears after the first wrap.
- Write ch0 R=2 in the exact cycle ch0 wraps:
  - Next period is still 4 and pulses continue at the old spacing.
  - From the following wrap, pulses every 2 cycles.
  - A second write while pending sees `cfg_ready_o`=0 and is not accepted.
- Write R=0 to ch2, enable: behaves as R=1 (`clk_o[2]` constantly high after 1 cycle). Drop `en_i[2]` mid-run: `clk_o[2]`=0 next cycle.
- Assert `rst_ni` low mid-period with a write pending:
  - Outputs and `cfg_pend_o` go to 0 immediately.
  - After release, channels run at R=4 pulse.
- With `PRIM_CLK_DIV_PROG_TESTMODE_EN` defined, `testmode_i`=1: all `clk_o` follow `clk_i`. Without the macro, the same stimulus has no effect.
